// File: rtl/vol_calc_if.sv
// Handshake bundle for vol_calc: (mean, second moment) in, (variance, std dev) out.
interface vol_calc_if #(
  parameter int data_width = 8
);
  logic [data_width-1:0]   mean_in;
  logic [2*data_width-1:0] sec_mom_in;
  logic                    in_valid;
  logic                    in_ready;
  logic [2*data_width-1:0] var_out;
  logic [data_width-1:0]   std_out;
  logic                    var_sat;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output mean_in, sec_mom_in, in_valid, out_ready,
    input  in_ready, var_out, std_out, var_sat, out_valid
  );

  modport slave (
    input  mean_in, sec_mom_in, in_valid, out_ready,
    output in_ready, var_out, std_out, var_sat, out_valid
  );
endinterface

// File: rtl/vol_calc.sv
// Rolling variance (E[x^2] - E[x]^2, clamped at 0) and restoring square root for volatility.
// Define VOL_SQRT_EN to build the square-root stage; otherwise std_out is tied to 0.
module vol_calc #(
  parameter int data_width = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  vol_calc_if.slave   bus
);
  localparam int DW = data_width;
  localparam int W2 = 2 * data_width;

`ifdef VOL_SQRT_EN
  typedef enum logic [1:0] {IDLE, SUB, SQRT, DONE} state_t;
  localparam int CW = (DW > 1) ? $clog2(DW) : 1;
`else
  typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;
`endif

  state_t          r_state;
  state_t          w_next;
  logic [DW-1:0]   r_mean;
  logic [W2-1:0]   r_m2;
  logic [W2-1:0]   r_var;
  logic            r_sat;
  logic [W2-1:0]   w_sq;
  logic [W2-1:0]   w_var;
  logic            w_sat;
  logic            w_accept;

  assign w_accept = bus.in_valid && (r_state == IDLE);
  assign w_sq     = {{DW{1'b0}}, r_mean} * {{DW{1'b0}}, r_mean};
  assign w_sat    = (w_sq > r_m2);
  assign w_var    = w_sat ? '0 : (r_m2 - w_sq);

`ifdef VOL_SQRT_EN
  logic [W2-1:0]   r_rad;
  logic [DW+1:0]   r_rem;
  logic [DW-1:0]   r_root;
  logic [CW-1:0]   r_cnt;
  logic [DW+1:0]   w_rem_sh;
  logic [DW+1:0]   w_sub;
  logic            w_ge;
  logic            w_last;

  // Bring down the next radicand bit pair and trial-subtract 4*root+1.
  assign w_rem_sh = (r_rem << 2) | {{DW{1'b0}}, r_rad[W2-1 -: 2]};
  assign w_sub    = {r_root, 2'b01};
  assign w_ge     = (w_rem_sh >= w_sub);
  assign w_last   = (r_cnt == CW'(DW - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (bus.in_valid) w_next = SUB;
`ifdef VOL_SQRT_EN
      SUB:  w_next = SQRT;
      SQRT: if (w_last) w_next = DONE;
`else
      SUB:  w_next = DONE;
`endif
      DONE: if (bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mean <= '0;
      r_m2   <= '0;
      r_var  <= '0;
      r_sat  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mean <= bus.mean_in;
        r_m2   <= bus.sec_mom_in;
      end
      if (r_state == SUB) begin
        r_var <= w_var;
        r_sat <= w_sat;
      end
    end
  end

`ifdef VOL_SQRT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rad  <= '0;
      r_rem  <= '0;
      r_root <= '0;
      r_cnt  <= '0;
    end else if (r_state == SUB) begin
      r_rad  <= w_var;
      r_rem  <= '0;
      r_root <= '0;
      r_cnt  <= '0;
    end else if (r_state == SQRT) begin
      r_rad  <= r_rad << 2;
      r_rem  <= w_ge ? (w_rem_sh - w_sub) : w_rem_sh;
      r_root <= (r_root << 1) | DW'(w_ge);
      r_cnt  <= r_cnt + CW'(1);
    end
  end

  assign bus.std_out = r_root;
`else
  assign bus.std_out = '0;
`endif

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.var_out   = r_var;
  assign bus.var_sat   = r_sat;
endmodule

// File: tb/tb_vol_calc.sv
// Scoreboard bench for vol_calc: driver pushes model results, negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_vol_calc;
  localparam int DW = 8;
  localparam int W2 = 2 * DW;
`ifdef VOL_SQRT_EN
  localparam int LAT = DW + 2;
`else
  localparam int LAT = 2;
`endif

  typedef struct {
    int v;
    int s;
    int sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t q[$];
  bit   rdy_force = 1'b1;
  bit   rdy_val = 1'b1;

  vol_calc_if #(.data_width(DW)) vif ();
  vol_calc #(.data_width(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(vif));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input int m, input int m2);
    exp_t e;
    int   sq;
    sq    = m * m;
    e.sat = (sq > m2) ? 1 : 0;
    e.v   = (sq > m2) ? 0 : m2 - sq;
    e.s   = 0;
`ifdef VOL_SQRT_EN
    while ((e.s + 1) * (e.s + 1) <= e.v) e.s++;
`endif
    return e;
  endfunction

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  task automatic send(input int m, input int m2);
    int n = 0;
    vif.mean_in    = DW'(m);
    vif.sec_mom_in = W2'(m2);
    vif.in_valid   = 1'b1;
    @(negedge clk);
    while (!vif.in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!vif.in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: in_ready got 0 expected 1");
    end else begin
      q.push_back(model(m, m2));
    end
    @(posedge clk);
    #1;
    vif.in_valid   = 1'b0;
    vif.mean_in    = DW'($urandom);
    vif.sec_mom_in = W2'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || !vif.in_ready) && n < 1000) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (n >= 1000) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: pending got %0d expected 0", q.size());
    end
  endtask

  // out_ready is either forced by the main sequence or randomised every cycle
  initial begin
    vif.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      vif.out_ready = rdy_force ? rdy_val : ($urandom_range(0, 1) == 1);
    end
  end

  bit p_hs, p_stall, p_valid, p_sat;
  int p_var, p_std;
  int acc_c = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      p_hs = 0; p_stall = 0; p_valid = 0;
    end else begin
      if (p_hs) begin
        chk("post_hs_in_ready", int'(vif.in_ready), 1);
        chk("post_hs_out_valid", int'(vif.out_valid), 0);
      end
      if (p_stall) begin
        chk("stall_out_valid", int'(vif.out_valid), 1);
        chk("stall_in_ready", int'(vif.in_ready), 0);
        chk("stall_var", int'(vif.var_out), p_var);
        chk("stall_std", int'(vif.std_out), p_std);
        chk("stall_sat", int'(vif.var_sat), int'(p_sat));
      end
      if (vif.in_valid && vif.in_ready) acc_c = cyc;
      if (vif.out_valid && !p_valid) chk("latency", cyc - acc_c, LAT);
      if (vif.out_valid && vif.out_ready) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: var got %0d expected none", vif.var_out);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("var_out", int'(vif.var_out), e.v);
          chk("std_out", int'(vif.std_out), e.s);
          chk("var_sat", int'(vif.var_sat), e.sat);
        end
      end
      p_hs    = vif.out_valid && vif.out_ready;
      p_stall = vif.out_valid && !vif.out_ready;
      p_valid = vif.out_valid;
      p_var   = int'(vif.var_out);
      p_std   = int'(vif.std_out);
      p_sat   = vif.var_sat;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time got %0t expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int m, m2, w;
    rst_n          = 1'b0;
    vif.in_valid   = 1'b0;
    vif.mean_in    = '0;
    vif.sec_mom_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(vif.in_ready), 1);
    chk("rst_out_valid", int'(vif.out_valid), 0);
    chk("rst_var", int'(vif.var_out), 0);
    chk("rst_std", int'(vif.std_out), 0);
    chk("rst_sat", int'(vif.var_sat), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // directed values including extremes and the clamp / recovery pair
    send(10, 125);   drain();
    send(0, 65535);
    send(255, 65025);
    send(0, 99);
    send(20, 300);
    send(3, 10);
    drain();

    // backpressure: hold DONE for 5 cycles while wiggling the input side
    rdy_val = 1'b0;
    @(posedge clk);
    #1;
    send(12, 200);
    w = 0;
    while (!vif.out_valid && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("bp_reached_done", int'(vif.out_valid), 1);
    repeat (5) begin
      vif.in_valid   = 1'b1;
      vif.mean_in    = DW'($urandom);
      vif.sec_mom_in = W2'($urandom);
      @(posedge clk);
      #1;
      chk("bp_in_ready", int'(vif.in_ready), 0);
    end
    vif.in_valid = 1'b0;
    rdy_val      = 1'b1;
    drain();

    // reset in the 4th SQRT cycle aborts the transaction
    send(7, 200);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", int'(vif.in_ready), 1);
    chk("abort_out_valid", int'(vif.out_valid), 0);
    chk("abort_var", int'(vif.var_out), 0);
    chk("abort_std", int'(vif.std_out), 0);
    chk("abort_sat", int'(vif.var_sat), 0);
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(4, 52);
    drain();

    // randomised traffic with random consumer stalls
    rdy_force = 1'b0;
    for (int i = 0; i < 40; i++) begin
      m = int'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) m2 = int'($urandom_range(0, 65535));
      else begin
        m2 = m * m + int'($urandom_range(0, 600)) - 300;
        if (m2 < 0) m2 = 0;
        if (m2 > 65535) m2 = 65535;
      end
      send(m, m2);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    drain();
    rdy_force = 1'b1;
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vol_calc.md
# vol_calc

Downstream of the squared-input moving-mean stage and the fixed SMA, this block computes rolling variance and volatility. It accepts one (mean, second moment) pair per transaction and forms variance = E[x²] − (E[x])², clamping at zero. It then runs an iterative restoring square root, one result bit per cycle, to produce the standard deviation. The outputs feed the signal/threshold logic over a valid/ready handshake.

## Interface
- `data_width`, default 8: bit width of the raw price sample and of the mean input.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `mean_in` input, `data_width` bits: window mean of x, from the SMA stage.
- `sec_mom_in` input, `2*data_width` bits: window mean of x², from the squared-mean stage.
- `in_valid` input, 1 bit: the input pair is valid.
- `in_ready` output, 1 bit: the block can accept a pair.
- `var_out` output, `2*data_width` bits: variance.
- `std_out` output, `data_width` bits: floor(sqrt(`var_out`)).
- `var_sat` output, 1 bit: the subtraction underflowed and was clamped to 0.
- `out_valid` output, 1 bit: the results are valid.
- `out_ready` input, 1 bit: the consumer accepts the results.

## Operation
- FSM states: IDLE, SUB, SQRT, DONE.
- IDLE
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`, capture `mean_in` and `sec_mom_in` into registers and go to SUB.
- SUB (one cycle)
  - Compute sq = mean·mean, unsigned, at `2*data_width` bits.
  - If sq > m2: var=0 and `var_sat`=1. Otherwise var=m2−sq and `var_sat`=0.
  - Register var and go to SQRT.
- SQRT (exactly `data_width` cycles)
  - Restoring digit-by-digit integer square root.
  - Each cycle consumes 2 bits of the radicand (MSB first) and yields one root bit.
  - An internal counter runs 0..`data_width`−1. On its last value, go to DONE.
- DONE
  - `out_valid`=1.
  - `var_out`, `std_out` and `var_sat` hold stable until `out_valid`&&`out_ready`, then go to IDLE.
- `in_ready`=0 in every state except IDLE. There is no input buffering.
- Inputs are sampled only at the accept edge. Later changes to `mean_in` or `sec_mom_in` have no effect on the transaction.
- Arithmetic is unsigned throughout. The remainder register is `data_width+2` bits, so there is no overflow.
- Results are exact: `std_out`² ≤ `var_out` < (`std_out`+1)².

## Timing
- Reset (asynchronous assert, any state):
  - FSM goes to IDLE.
  - `in_ready`=1, `out_valid`=0, `var_out`=0, `std_out`=0, `var_sat`=0.
  - Counter and datapath registers clear.
  - Reset mid-SQRT aborts the transaction with no output.
- Deassertion is synchronised externally. The first accept is possible on the first rising edge after `rst_n` goes high.
- Latency with the macro defined:
  - Accept at edge A.
  - SUB at edge A+1.
  - SQRT at edges A+2..A+`data_width`+1.
  - `out_valid`=1 after edge A+`data_width`+2, i.e. 10 cycles for `data_width`=8.
- Throughput: one transaction per `data_width`+3 cycles when `out_ready`=1 is held.
- `out_valid` never deasserts without a handshake.
- The DONE→IDLE transition and the next accept cannot share an edge. `in_ready` rises the cycle after the output handshake.
- `out_ready` is ignored outside DONE.

## Configuration
- Macro: `VOL_SQRT_EN`.
- Defined:
  - Full behaviour as above.
  - `std_out` = floor(sqrt(var)).
- Undefined:
  - SQRT state and counter are not compiled.
  - SUB goes directly to DONE, so `out_valid`=1 after edge A+2.
  - `std_out` is tied to 0.
  - `var_out` and `var_sat` behave identically to the defined case.

## Test plan
All scenarios use `data_width`=8 and the macro defined unless noted.
- **Basic:** `mean_in`=10, `sec_mom_in`=125 → `var_out`=25, `std_out`=5, `var_sat`=0, with `out_valid` rising 10 cycles after accept.
- **Extremes:**
  - `mean_in`=0, `sec_mom_in`=65535 → `var_out`=65535, `std_out`=255.
  - `mean_in`=255, `sec_mom_in`=65025 → `var_out`=0, `std_out`=0.
  - Non-square: `mean_in`=0, `sec_mom_in`=99 → `std_out`=9.
- **Clamp:** `mean_in`=20, `sec_mom_in`=300 → `var_out`=0, `std_out`=0, `var_sat`=1. The next transaction with `mean_in`=3, `sec_mom_in`=10 → `var_sat`=0, `var_out`=1, `std_out`=1.
- **Backpressure:** hold `out_ready`=0 for 5 cycles in DONE → outputs stable, `in_ready`=0, and changes on `in_valid`/data are ignored. Then `out_ready`=1 → one handshake, with `in_ready`=1 on the following cycle.
- **Reset abort:** pulse `rst_n` low during the 4th SQRT cycle → all outputs return to reset values immediately. A fresh transaction (`mean_in`=4, `sec_mom_in`=52) → `var_out`=36, `std_out`=6.
- **Macro undefined:** rerun the basic case → `var_out`=25, `std_out`=0, `out_valid` 2 cycles after accept.
